// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx - 8-bit serial UART transmitter for the TXD pad.
//
// Accepts one byte per valid/ready handshake and sends it LSB first as an
// 8N1 frame (8N2 with STOP_BITS=2). Every bit is held for DIV clk cycles,
// where DIV = CLK_FREQ_HZ / BAUD (integer division, must be >= 2).
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit is inserted after the data
//                      bits: XOR of the 8 data bits XOR PARITY_ODD.
//                      When undefined, no parity logic is built.
//
// Ports:
//   clk       in   system clock, rising edge active
//   resetn    in   asynchronous active-low reset
//   tx_data   in   [7:0] byte to send, sampled on the handshake edge
//   tx_valid  in   requester has a byte on tx_data
//   tx_ready  out  block accepts a byte this cycle (registered, IDLE only)
//   tx_busy   out  a frame is on the line (registered, = !tx_ready)
//   TXD       out  serial line, idle high (registered)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line high, tx_ready=1, waiting for tx_valid
// START   | start bit (0) for DIV cycles
// DATA    | 8 data bits, LSB first, DIV cycles each
// PARITY  | parity bit for DIV cycles (UART_TX_PARITY_EN only)
// STOP    | line high for STOP_BITS*DIV cycles, then back to IDLE
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       TXD
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    // The bit counter doubles as the stop-bit counter while in STOP.
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if ((DIV < 2) || ((STOP_BITS != 1) && (STOP_BITS != 2)) ||
            ((PARITY_ODD != 0) && (PARITY_ODD != 1))) begin : g_bad_cfg
            $error("uart_tx: illegal parameter set");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [CNT_W-1:0] w_baud_cnt_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_txd;
    logic             w_txd_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             r_busy;
    logic             w_baud_done;

`ifdef UART_TX_PARITY_EN
    // The shift register is empty by the time the parity bit goes out, so
    // parity is computed once from the byte on the handshake edge.
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_txd_nxt      = r_txd;
        w_ready_nxt    = r_ready;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt   = r_parity;
`endif

        // The baud counter runs in every non-IDLE state and restarts at each
        // bit boundary; IDLE leaves it at zero.
        if (r_state != S_IDLE) begin
            w_baud_cnt_nxt = w_baud_done ? '0 : r_baud_cnt + CNT_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_txd_nxt   = 1'b1;
                w_ready_nxt = 1'b1;
                if (tx_valid && r_ready) begin
                    w_state_nxt    = S_START;
                    w_shift_nxt    = tx_data;
                    w_txd_nxt      = 1'b0;
                    w_ready_nxt    = 1'b0;
                    w_baud_cnt_nxt = '0;
                    w_bit_cnt_nxt  = 3'd0;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end

            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                end
            end

            S_DATA: begin
                if (w_baud_done) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt   = S_PARITY;
                        w_txd_nxt     = r_parity;
`else
                        w_state_nxt   = S_STOP;
                        w_txd_nxt     = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_txd_nxt     = r_shift[0];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif

            S_STOP: begin
                w_txd_nxt = 1'b1;
                if (w_baud_done) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_ready_nxt   = 1'b1;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_txd_nxt      = 1'b1;
                w_ready_nxt    = 1'b1;
                w_baud_cnt_nxt = '0;
                w_bit_cnt_nxt  = 3'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_txd      <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_txd      <= w_txd_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= !w_ready_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    assign TXD      = r_txd;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx - bench for uart_tx.
// Two instances share clk/resetn:
//   A: DIV=8 (8 Hz / 1 baud), 1 stop bit, even parity sense
//   B: DIV=4 (4 Hz / 1 baud), 2 stop bits, odd parity sense
// A frame model predicts TXD/tx_ready/tx_busy of both every cycle; a serial
// receiver model on A recovers the bytes from the line.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int DIV_A  = 8;
    localparam int STOP_A = 1;
    localparam int ODD_A  = 0;
    localparam int DIV_B  = 4;
    localparam int STOP_B = 2;
    localparam int ODD_B  = 1;
    // Frame = start + 8 data + parity + stop bits, each DIV cycles.
    localparam int FL_A = (1 + 8 + P + STOP_A) * DIV_A;
    localparam int FL_B = (1 + 8 + P + STOP_B) * DIV_B;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready, a_busy, b_busy, a_txd, b_txd;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ_HZ(8), .BAUD(1), .STOP_BITS(STOP_A), .PARITY_ODD(ODD_A)) u_dut_a (
        .clk(clk), .resetn(resetn), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx_busy(a_busy), .TXD(a_txd));

    uart_tx #(.CLK_FREQ_HZ(4), .BAUD(1), .STOP_BITS(STOP_B), .PARITY_ODD(ODD_B)) u_dut_b (
        .clk(clk), .resetn(resetn), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx_busy(b_busy), .TXD(b_txd));

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level at bit position idx of the frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int idx, input int odd);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (P == 1 && idx == 9) return (^d) ^ odd[0];
        return 1'b1;
    endfunction

    // ---------------- frame model ----------------
    int         cyc = 0;
    bit         ma_act = 0, mb_act = 0;
    int         ma_start = 0, mb_start = 0;
    logic [7:0] ma_byte = 8'h00, mb_byte = 8'h00;
    int         ma_hs[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ma_act = 0;
            mb_act = 0;
        end else begin
            cyc++;
            if (ma_act) begin
                if (cyc - ma_start == FL_A) ma_act = 0;
            end else if (a_valid) begin
                ma_act = 1; ma_start = cyc; ma_byte = a_data; ma_hs.push_back(cyc);
            end
            if (mb_act) begin
                if (cyc - mb_start == FL_B) mb_act = 0;
            end else if (b_valid) begin
                mb_act = 1; mb_start = cyc; mb_byte = b_data;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_a, exp_b;
        if (chk_en) begin
            exp_a = ma_act ? frame_bit(ma_byte, (cyc - ma_start) / DIV_A, ODD_A) : 1'b1;
            exp_b = mb_act ? frame_bit(mb_byte, (cyc - mb_start) / DIV_B, ODD_B) : 1'b1;
            check("a_txd",   a_txd,   exp_a);
            check("a_ready", a_ready, !ma_act);
            check("a_busy",  a_busy,  ma_act);
            check("b_txd",   b_txd,   exp_b);
            check("b_ready", b_ready, !mb_act);
            check("b_busy",  b_busy,  mb_act);
        end
    end

    // ---------------- serial receiver on A ----------------
    int         rx_cnt = -1;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];

    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (a_txd == 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if ((rx_cnt % DIV_A) == DIV_A / 2 && rx_cnt / DIV_A >= 1 && rx_cnt / DIV_A <= 8)
                rx_sh[rx_cnt / DIV_A - 1] = a_txd;
            if (rx_cnt == (9 + P) * DIV_A + DIV_A / 2) begin
                rx_q.push_back(rx_sh);
                rx_cnt = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic cap[0:255];
    int   cap_len;

    task automatic wait_ready(input bit sel, input logic lvl, input int lim, input string name);
        int g = 0;
        while (((sel ? b_ready : a_ready) !== lvl) && g < lim) begin
            @(negedge clk);
            g++;
        end
        check(name, (g < lim), 1);
    endtask

    // Sends one byte and records TXD at every cycle while tx_ready is low.
    task automatic run_frame(input bit sel, input logic [7:0] d);
        @(negedge clk);
        if (sel) begin b_data = d; b_valid = 1'b1; end
        else     begin a_data = d; a_valid = 1'b1; end
        wait_ready(sel, 1'b0, 10, "tmo_accept");
        a_valid = 1'b0;
        b_valid = 1'b0;
        cap_len = 0;
        while (((sel ? b_ready : a_ready) == 1'b0) && cap_len < 256) begin
            cap[cap_len] = sel ? b_txd : a_txd;
            cap_len++;
            @(negedge clk);
        end
    endtask

    logic [0:10] seq_a5;

    initial begin
        int idle_n;
        a_valid = 0; b_valid = 0; a_data = 8'h00; b_data = 8'h00;
`ifdef UART_TX_PARITY_EN
        seq_a5 = 11'b0_1010_0101_01;
`else
        seq_a5 = 11'b0_1010_0101_11;
`endif
        // ---- reset ----
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd",   a_txd,   1'b1);
        check("rst_ready", a_ready, 1'b1);
        check("rst_busy",  a_busy,  1'b0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_txd",   a_txd,   1'b1);
        check("post_rst_ready", b_ready, 1'b1);
        chk_en = 1;

        // ---- single byte 0xA5 ----
        rx_q.delete();
        run_frame(0, 8'hA5);
        check("a5_len", cap_len, (P == 1) ? 88 : 80);
        for (int j = 0; j < 10 + P; j++) begin
            check("a5_bit_first", cap[j*8],     seq_a5[j]);
            check("a5_bit_last",  cap[j*8 + 7], seq_a5[j]);
        end
        repeat (4) @(negedge clk);
        check("a5_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) check("a5_rx_byte", rx_q[0], 8'hA5);

        // ---- back-to-back 0x00 then 0xFF ----
        rx_q.delete();
        ma_hs.delete();
        @(negedge clk);
        a_data = 8'h00; a_valid = 1'b1;
        wait_ready(0, 1'b0, 10, "tmo_b2b_acc1");
        a_data = 8'hFF;
        wait_ready(0, 1'b1, 200, "tmo_b2b_end1");
        idle_n = 0;
        while (a_ready && idle_n < 10) begin
            idle_n++;
            @(negedge clk);
        end
        a_valid = 1'b0;
        check("b2b_idle_gap", idle_n, 1);
        wait_ready(0, 1'b1, 200, "tmo_b2b_end2");
        repeat (3) @(negedge clk);
        check("b2b_hs_n", ma_hs.size(), 2);
        if (ma_hs.size() == 2) check("b2b_hs_spacing", ma_hs[1] - ma_hs[0], (P == 1) ? 89 : 81);
        check("b2b_rx_n", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", rx_q[0], 8'h00);
            check("b2b_rx1", rx_q[1], 8'hFF);
        end

        // ---- request while busy is ignored ----
        rx_q.delete();
        ma_hs.delete();
        @(negedge clk);
        a_data = 8'hC3; a_valid = 1'b1;
        wait_ready(0, 1'b0, 10, "tmo_ign_acc");
        a_valid = 1'b0;
        repeat (30) @(negedge clk);
        a_data = 8'h3C; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; a_data = 8'h55;
        wait_ready(0, 1'b1, 200, "tmo_ign_end");
        repeat (20) @(negedge clk);
        check("ign_ready", a_ready, 1'b1);
        check("ign_hs_n", ma_hs.size(), 1);
        check("ign_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) check("ign_rx_byte", rx_q[0], 8'hC3);

        // ---- two stop bits, DIV=4, 0x81 ----
        run_frame(1, 8'h81);
        check("s2_len",    cap_len, (P == 1) ? 48 : 44);
        check("s2_start",  cap[0], 1'b0);
        check("s2_bit0",   cap[4], 1'b1);
        check("s2_bit1",   cap[8], 1'b0);
        check("s2_bit7",   cap[35], 1'b1);
        for (int k = 0; k < 8; k++) check("s2_stop_high", cap[(9 + P) * 4 + k], 1'b1);

`ifdef UART_TX_PARITY_EN
        // ---- parity ----
        run_frame(0, 8'h07);
        check("par_even_len", cap_len, 88);
        check("par_even_bit", cap[76], 1'b1);
        run_frame(1, 8'h07);
        check("par_odd_len",  cap_len, 48);
        check("par_odd_bit",  cap[38], 1'b0);
`endif

        // ---- asynchronous reset mid-frame ----
        @(negedge clk);
        a_data = 8'hA5; a_valid = 1'b1;
        wait_ready(0, 1'b0, 10, "tmo_ar_acc");
        a_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("ar_pre_txd", a_txd, 1'b0);
        #1 resetn = 1'b0;
        #1;
        check("ar_async_txd",   a_txd,   1'b1);
        check("ar_async_ready", a_ready, 1'b1);
        check("ar_async_busy",  a_busy,  1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("ar_rel_ready", a_ready, 1'b1);
        check("ar_rel_txd",   a_txd,   1'b1);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
